// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - branch opcodes, forwarding selects, stall FSM states and hazard helper
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BEQ     = 3'd1,
    BNE     = 3'd2,
    BLEZ    = 3'd3,
    BGTZ    = 3'd4,
    BLTZ    = 3'd5,
    BGEZ    = 3'd6,
    BR_RSV  = 3'd7
  } br_op_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  function automatic logic is_branch(input logic [2:0] op);
    return (op != BR_NONE) && (op != BR_RSV);
  endfunction

  function automatic logic uses_rt(input logic [2:0] op);
    return (op == BEQ) || (op == BNE);
  endfunction

  // Stall cycles needed before register r can be compared in ID; $0 never stalls.
  function automatic logic [1:0] hazard_need(
    input logic [4:0] r,
    input logic [4:0] ex_rw,
    input logic       ex_regwrite,
    input logic       ex_memread,
    input logic [4:0] mem_rw,
    input logic       mem_memread
  );
    if (r == 5'd0)                        return 2'd0;
    if (ex_regwrite && (ex_rw == r))      return ex_memread ? 2'd2 : 2'd1;
    if (mem_memread && (mem_rw == r))     return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - ID-stage branch resolver signal bundle
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [2:0]        id_br_op;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [1:0]        br_fwd_a;
  logic [1:0]        br_fwd_b;
  logic [DATA_W-1:0] alu_out_mem;
  logic [DATA_W-1:0] load_data_wb;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [15:0]       id_imm16;
  logic [4:0]        ex_rw;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [4:0]        mem_rw;
  logic              mem_memread;
  logic              id_kill;
  logic              stall_id;
  logic              pc_redirect;
  logic [DATA_W-1:0] pc_target;
  logic              flush_if_id;
  logic [CNT_W-1:0]  cnt_branch;
  logic [CNT_W-1:0]  cnt_taken;
  logic [CNT_W-1:0]  cnt_stall;

  modport slave (
    input  id_valid, id_br_op, id_rs, id_rt, rf_rdata_a, rf_rdata_b,
           br_fwd_a, br_fwd_b, alu_out_mem, load_data_wb, id_pc_plus4, id_imm16,
           ex_rw, ex_regwrite, ex_memread, mem_rw, mem_memread, id_kill,
    output stall_id, pc_redirect, pc_target, flush_if_id,
           cnt_branch, cnt_taken, cnt_stall
  );

  modport master (
    output id_valid, id_br_op, id_rs, id_rt, rf_rdata_a, rf_rdata_b,
           br_fwd_a, br_fwd_b, alu_out_mem, load_data_wb, id_pc_plus4, id_imm16,
           ex_rw, ex_regwrite, ex_memread, mem_rw, mem_memread, id_kill,
    input  stall_id, pc_redirect, pc_target, flush_if_id,
           cnt_branch, cnt_taken, cnt_stall
  );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// rtl/branch_resolve_unit_compare.sv - signed branch condition evaluation
import branch_pkg::*;

module branch_compare #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken
);
  logic a_neg;
  logic a_zero;

  assign a_neg  = a[DATA_W-1];
  assign a_zero = (a == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      BEQ:     taken = (a == b);
      BNE:     taken = (a != b);
      BLEZ:    taken = a_neg | a_zero;
      BGTZ:    taken = ~a_neg & ~a_zero;
      BLTZ:    taken = a_neg;
      BGEZ:    taken = ~a_neg;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolver: stall FSM, operand mux, target, perf counters
import branch_pkg::*;

module branch_resolve_unit #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int DELAY_SLOT = 0
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);
  br_state_e         state_q, state_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;

  logic              live;
  logic              br_ok;
  logic [1:0]        need_a, need_b, need;
  logic              stall;
  logic              resolve;
  logic              taken;
  logic [DATA_W-1:0] op_a, op_b;

  // Everything combinational goes quiet while reset is held, so a reset mid-stall releases ID at once.
  assign live  = bus.id_valid & ~reset;
  assign br_ok = live & is_branch(bus.id_br_op);

  assign need_a = hazard_need(bus.id_rs, bus.ex_rw, bus.ex_regwrite, bus.ex_memread,
                              bus.mem_rw, bus.mem_memread);
  assign need_b = uses_rt(bus.id_br_op)
                ? hazard_need(bus.id_rt, bus.ex_rw, bus.ex_regwrite, bus.ex_memread,
                              bus.mem_rw, bus.mem_memread)
                : 2'd0;
  assign need   = (need_a > need_b) ? need_a : need_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      stall_cnt_q  <= 2'd0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.id_kill) begin
      state_d     = ST_RUN;
      stall_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (br_ok && (need != 2'd0)) begin
            stall_cnt_d = need - 2'd1;
            state_d     = (need > 2'd1) ? ST_WAIT : ST_RUN;
          end
        end
        ST_WAIT: begin
          stall_cnt_d = stall_cnt_q - 2'd1;
          if (stall_cnt_q <= 2'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (live && !bus.id_kill) begin
      case (state_q)
        ST_RUN:  stall = br_ok && (need != 2'd0);
        ST_WAIT: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (bus.br_fwd_a)
      FWD_MEM: op_a = bus.alu_out_mem;
      FWD_WB:  op_a = bus.load_data_wb;
      default: op_a = bus.rf_rdata_a;
    endcase
    case (bus.br_fwd_b)
      FWD_MEM: op_b = bus.alu_out_mem;
      FWD_WB:  op_b = bus.load_data_wb;
      default: op_b = bus.rf_rdata_b;
    endcase
  end

  branch_compare #(.DATA_W(DATA_W)) u_cmp (
    .op    (bus.id_br_op),
    .a     (op_a),
    .b     (op_b),
    .taken (taken)
  );

  assign resolve = br_ok & ~stall & ~bus.id_kill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  assign cnt_branch_d = sat_inc(cnt_branch_q, resolve);
  assign cnt_taken_d  = sat_inc(cnt_taken_q, resolve & taken);
  assign cnt_stall_d  = sat_inc(cnt_stall_q, stall);

  assign bus.stall_id    = stall;
  assign bus.pc_redirect = resolve & taken;
  assign bus.flush_if_id = resolve & taken & (DELAY_SLOT == 0);
  assign bus.pc_target   = live
                         ? bus.id_pc_plus4 + {{(DATA_W-18){bus.id_imm16[15]}}, bus.id_imm16, 2'b00}
                         : '0;
  assign bus.cnt_branch  = cnt_branch_q;
  assign bus.cnt_taken   = cnt_taken_q;
  assign bus.cnt_stall   = cnt_stall_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized checks against a behavioural model
import branch_pkg::*;

module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DATA_W(32), .CNT_W(32)) bif();
  branch_resolve_unit_if #(.DATA_W(32), .CNT_W(4))  sif();

  branch_resolve_unit #(.DATA_W(32), .CNT_W(32), .DELAY_SLOT(0)) dut (
    .clk(clk), .reset(reset), .bus(bif.slave));
  branch_resolve_unit #(.DATA_W(32), .CNT_W(4), .DELAY_SLOT(1)) dut_s (
    .clk(clk), .reset(reset), .bus(sif.slave));

  assign sif.id_valid     = bif.id_valid;
  assign sif.id_br_op     = bif.id_br_op;
  assign sif.id_rs        = bif.id_rs;
  assign sif.id_rt        = bif.id_rt;
  assign sif.rf_rdata_a   = bif.rf_rdata_a;
  assign sif.rf_rdata_b   = bif.rf_rdata_b;
  assign sif.br_fwd_a     = bif.br_fwd_a;
  assign sif.br_fwd_b     = bif.br_fwd_b;
  assign sif.alu_out_mem  = bif.alu_out_mem;
  assign sif.load_data_wb = bif.load_data_wb;
  assign sif.id_pc_plus4  = bif.id_pc_plus4;
  assign sif.id_imm16     = bif.id_imm16;
  assign sif.ex_rw        = bif.ex_rw;
  assign sif.ex_regwrite  = bif.ex_regwrite;
  assign sif.ex_memread   = bif.ex_memread;
  assign sif.mem_rw       = bif.mem_rw;
  assign sif.mem_memread  = bif.mem_memread;
  assign sif.id_kill      = bif.id_kill;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: stall cycles still owed, and event totals
  int    m_wait;
  longint m_br, m_tk, m_st;
  logic  obs_stall, obs_redirect, obs_flush;
  logic [31:0] obs_target;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int dep_need(input logic [4:0] r);
    if (r == 0) return 0;
    if (bif.ex_regwrite && bif.ex_rw == r) return bif.ex_memread ? 2 : 1;
    if (bif.mem_memread && bif.mem_rw == r) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 1) return bif.alu_out_mem;
    if (sel == 2) return bif.load_data_wb;
    return rf;
  endfunction

  task automatic set_idle();
    bif.id_valid = 0; bif.id_br_op = 0; bif.id_rs = 0; bif.id_rt = 0;
    bif.rf_rdata_a = 0; bif.rf_rdata_b = 0; bif.br_fwd_a = 0; bif.br_fwd_b = 0;
    bif.alu_out_mem = 0; bif.load_data_wb = 0; bif.id_pc_plus4 = 0; bif.id_imm16 = 0;
    bif.ex_rw = 0; bif.ex_regwrite = 0; bif.ex_memread = 0;
    bif.mem_rw = 0; bif.mem_memread = 0; bif.id_kill = 0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_br = 0; m_tk = 0; m_st = 0;
  endtask

  // One clock: inputs are already applied; compare at negedge, advance model at posedge.
  task automatic tick();
    int need, sa, off;
    bit br, stall, taken, resolve, redirect;
    logic [31:0] a, b, tgt;
    @(negedge clk);
    br   = bif.id_valid && (bif.id_br_op >= 1) && (bif.id_br_op <= 6);
    a    = pick(bif.br_fwd_a, bif.rf_rdata_a);
    b    = pick(bif.br_fwd_b, bif.rf_rdata_b);
    sa   = int'(a);
    need = 0;
    if (m_wait > 0) stall = bif.id_valid && !bif.id_kill;
    else begin
      if (br && !bif.id_kill) begin
        need = dep_need(bif.id_rs);
        if ((bif.id_br_op == 1 || bif.id_br_op == 2) && dep_need(bif.id_rt) > need)
          need = dep_need(bif.id_rt);
      end
      stall = need > 0;
    end
    case (bif.id_br_op)
      3'd1: taken = (a == b);
      3'd2: taken = (a != b);
      3'd3: taken = (sa <= 0);
      3'd4: taken = (sa > 0);
      3'd5: taken = (sa < 0);
      3'd6: taken = (sa >= 0);
      default: taken = 0;
    endcase
    resolve  = br && !stall && !bif.id_kill;
    redirect = resolve && taken;
    off = int'($signed(bif.id_imm16)) * 4;
    tgt = bif.id_valid ? bif.id_pc_plus4 + 32'(off) : 32'd0;

    check("stall_id", bif.stall_id, stall);
    check("pc_redirect", bif.pc_redirect, redirect);
    check("flush_if_id", bif.flush_if_id, redirect);
    check("pc_target", bif.pc_target, tgt);
    check("cnt_branch", bif.cnt_branch, sat(m_br, 64'hFFFF_FFFF));
    check("cnt_taken", bif.cnt_taken, sat(m_tk, 64'hFFFF_FFFF));
    check("cnt_stall", bif.cnt_stall, sat(m_st, 64'hFFFF_FFFF));
    check("ds_stall_id", sif.stall_id, stall);
    check("ds_redirect", sif.pc_redirect, redirect);
    check("ds_no_flush", sif.flush_if_id, 1'b0);
    check("ds_cnt_branch", sif.cnt_branch, sat(m_br, 15));
    check("ds_cnt_taken", sif.cnt_taken, sat(m_tk, 15));
    check("ds_cnt_stall", sif.cnt_stall, sat(m_st, 15));
    obs_stall = bif.stall_id; obs_redirect = bif.pc_redirect;
    obs_flush = bif.flush_if_id; obs_target = bif.pc_target;

    m_br += resolve; m_tk += redirect; m_st += stall;
    if (bif.id_kill) m_wait = 0;
    else if (m_wait > 0) m_wait = m_wait - 1;
    else m_wait = stall ? need - 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard_bne();
    set_idle();
    bif.id_valid = 1; bif.id_br_op = BNE; bif.id_rs = 3; bif.id_rt = 0;
    bif.ex_rw = 3; bif.ex_regwrite = 1; bif.ex_memread = 1;
  endtask

  initial begin
    set_idle();
    model_reset();
    reset = 1;
    #12;
    check("rst_stall", bif.stall_id, 1'b0);
    check("rst_cnt_branch", bif.cnt_branch, 32'd0);
    check("rst_cnt_taken", bif.cnt_taken, 32'd0);
    check("rst_cnt_stall", bif.cnt_stall, 32'd0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // 1: plain BEQ taken
    set_idle();
    bif.id_valid = 1; bif.id_br_op = BEQ; bif.id_rs = 1; bif.id_rt = 2;
    bif.rf_rdata_a = 5; bif.rf_rdata_b = 5; bif.id_pc_plus4 = 32'h100; bif.id_imm16 = 4;
    tick();
    check("t1_redirect", obs_redirect, 1'b1);
    check("t1_target", obs_target, 32'h110);
    check("t1_flush", obs_flush, 1'b1);
    check("t1_cnt_taken", bif.cnt_taken, 32'd1);

    // 2: load in EX, two stall cycles, resolve with WB forward
    load_hazard_bne();
    tick();
    check("t2_stall0", obs_stall, 1'b1);
    bif.ex_regwrite = 0; bif.ex_memread = 0; bif.mem_rw = 3; bif.mem_memread = 1;
    tick();
    check("t2_stall1", obs_stall, 1'b1);
    bif.mem_memread = 0; bif.br_fwd_a = FWD_WB; bif.load_data_wb = 7;
    tick();
    check("t2_resolve_stall", obs_stall, 1'b0);
    check("t2_redirect", obs_redirect, 1'b1);
    check("t2_cnt_stall", bif.cnt_stall, 32'd2);

    // 3: ALU result in EX, one stall, MEM forward of a negative value
    set_idle();
    bif.id_valid = 1; bif.id_br_op = BLEZ; bif.id_rs = 4; bif.ex_rw = 4; bif.ex_regwrite = 1;
    tick();
    check("t3_stall", obs_stall, 1'b1);
    bif.ex_regwrite = 0; bif.br_fwd_a = FWD_MEM; bif.alu_out_mem = 32'h8000_0000;
    tick();
    check("t3_redirect", obs_redirect, 1'b1);

    // 4: $0 never hazards; negative offset
    set_idle();
    bif.id_valid = 1; bif.id_br_op = BGTZ; bif.id_rs = 0; bif.ex_rw = 0; bif.ex_regwrite = 1;
    bif.id_pc_plus4 = 32'h200; bif.id_imm16 = 16'hFFFF;
    tick();
    check("t4_stall", obs_stall, 1'b0);
    check("t4_redirect", obs_redirect, 1'b0);
    check("t4_target", obs_target, 32'h1FC);

    // 5: kill during WAIT, back in RUN on the next edge
    load_hazard_bne();
    tick();
    bif.id_kill = 1;
    tick();
    check("t5_kill_stall", obs_stall, 1'b0);
    check("t5_kill_redirect", obs_redirect, 1'b0);
    bif.id_kill = 0; bif.ex_regwrite = 0; bif.ex_memread = 0; bif.rf_rdata_a = 1;
    tick();
    check("t5_run_stall", obs_stall, 1'b0);
    check("t5_run_redirect", obs_redirect, 1'b1);

    // reset while in WAIT
    load_hazard_bne();
    tick();
    reset = 1;
    #1;
    check("rst_wait_stall", bif.stall_id, 1'b0);
    check("rst_wait_cnt_stall", bif.cnt_stall, 32'd0);
    check("rst_wait_cnt_branch", bif.cnt_branch, 32'd0);
    check("rst_wait_ds_cnt", sif.cnt_stall, 4'd0);
    model_reset();
    set_idle();
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // 6: 20 taken branches saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      set_idle();
      bif.id_valid = 1; bif.id_br_op = BEQ; bif.id_rs = 1; bif.id_rt = 2;
      bif.rf_rdata_a = i; bif.rf_rdata_b = i; bif.id_pc_plus4 = 32'h400;
      tick();
    end
    check("t6_ds_cnt_taken", sif.cnt_taken, 4'd15);
    check("t6_cnt_taken", bif.cnt_taken, 32'd20);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      bif.id_valid    = ($urandom_range(0, 7) != 0);
      bif.id_br_op    = 3'($urandom_range(0, 7));
      bif.id_rs       = 5'($urandom_range(0, 4));
      bif.id_rt       = 5'($urandom_range(0, 4));
      bif.rf_rdata_b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      bif.rf_rdata_a  = ($urandom_range(0, 3) == 0) ? bif.rf_rdata_b : $urandom;
      bif.br_fwd_a    = 2'($urandom_range(0, 3));
      bif.br_fwd_b    = 2'($urandom_range(0, 3));
      bif.alu_out_mem = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      bif.load_data_wb = $urandom;
      bif.id_pc_plus4 = $urandom;
      bif.id_imm16    = 16'($urandom);
      bif.ex_rw       = 5'($urandom_range(0, 4));
      bif.ex_regwrite = 1'($urandom_range(0, 1));
      bif.ex_memread  = 1'($urandom_range(0, 1));
      bif.mem_rw      = 5'($urandom_range(0, 4));
      bif.mem_memread = 1'($urandom_range(0, 1));
      bif.id_kill     = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
